jump_ctrl: RTL

Sequential jump-control unit for the multi-cycle MIPS datapath. It decodes J, JAL, JR and JALR from `op`/`funct`, computes and latches the jump target, and presents a PC redirect through a valid/ready handshake. It issues the link-register write for JAL/JALR, then holds a parametrised fetch-flush window. It extends the single-signal JR detect into the complete jump path, and adds misaligned-target fault reporting.

---
 rtl/jump_pkg.sv | 21 ++
 rtl/jump_decode.sv | 25 ++
 rtl/jump_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/jump_pkg.sv
// Shared constants and types for the MIPS jump-control path.
package jump_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_e;
  typedef enum logic [2:0] {NONE, J, JAL, JR, JALR} jump_kind_e;

  function automatic logic kind_links(jump_kind_e k);
    return (k == JAL) || (k == JALR);
  endfunction

  function automatic logic kind_uses_rs(jump_kind_e k);
    return (k == JR) || (k == JALR);
  endfunction

endpackage

// File: rtl/jump_decode.sv
// Combinational op/funct decode into a jump kind; shared with the hazard unit.
module jump_decode
  import jump_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [5:0]  funct_i,
  output jump_kind_e  kind_o,
  output logic        is_jump_o
);

  always_comb begin
    kind_o = NONE;
    case (op_i)
      OP_J:     kind_o = J;
      OP_JAL:   kind_o = JAL;
      OP_RTYPE: begin
        if (funct_i == FN_JR)        kind_o = JR;
        else if (funct_i == FN_JALR) kind_o = JALR;
      end
      default:  kind_o = NONE;
    endcase
    is_jump_o = (kind_o != NONE);
  end

endmodule

// File: rtl/jump_ctrl.sv
// Jump-control unit: latches jump target and link info, offers a PC redirect,
// issues the link write on acceptance, then holds a fetch-flush window.
//   state    | meaning
//   IDLE     | accepting instructions; jumps latched here, misaligned JR/JALR faulted
//   REDIRECT | redirect_pc offered, waiting for redirect_ready
//   FLUSH    | fetch squashed while the flush counter runs down
module jump_ctrl
  import jump_pkg::*;
#(
  parameter int          ADDR_W       = 32,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [4:0]  LINK_REG     = 5'd31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic [4:0]        rd,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] rs_value,
  input  logic [ADDR_W-1:0] pc_plus4,
  output logic              is_jump,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              link_we,
  output logic [4:0]        link_reg,
  output logic [ADDR_W-1:0] link_data,
  output logic              flush,
  output logic              misalign
);

  // Mask form keeps the J-target merge legal even when ADDR_W is exactly 28.
  localparam logic [ADDR_W-1:0] LOW28_MASK = ADDR_W'(28'hFFF_FFFF);
  localparam logic [3:0]        CNT_LOAD   = 4'(FLUSH_CYCLES - 1);

  jump_kind_e        kind;
  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] link_data_q, link_data_d;
  logic [4:0]        link_reg_q, link_reg_d;
  logic              link_q, link_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] j_target;

  jump_decode u_decode (
    .op_i      (op),
    .funct_i   (funct),
    .kind_o    (kind),
    .is_jump_o (is_jump)
  );

  assign j_target = (pc_plus4 & ~LOW28_MASK) | ADDR_W'({imm26, 2'b00});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pc_q        <= '0;
      link_data_q <= '0;
      link_reg_q  <= '0;
      link_q      <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      link_data_q <= link_data_d;
      link_reg_q  <= link_reg_d;
      link_q      <= link_d;
      misalign_q  <= misalign_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    link_data_d = link_data_q;
    link_reg_d  = link_reg_q;
    link_d      = link_q;
    misalign_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid && is_jump) begin
          if (kind_uses_rs(kind) && (rs_value[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
          end else begin
            pc_d    = kind_uses_rs(kind) ? rs_value : j_target;
            link_d  = kind_links(kind);
            state_d = REDIRECT;
            if (kind_links(kind)) begin
              link_reg_d  = (kind == JAL) ? LINK_REG : rd;
              link_data_d = pc_plus4;
            end
          end
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          cnt_d   = CNT_LOAD;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign instr_ready    = (state_q == IDLE);
  assign redirect_valid = (state_q == REDIRECT);
  assign flush          = (state_q == FLUSH);
  assign link_we        = (state_q == REDIRECT) && redirect_ready && link_q;
  assign redirect_pc    = pc_q;
  assign link_reg       = link_reg_q;
  assign link_data      = link_data_q;
  assign misalign       = misalign_q;

endmodule
